// File: rtl/i2c_target_if.sv
// Pin and register-side signal bundle for the I2C target.
interface i2c_target_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [7:0]  status_in;
    logic [23:0] reg_out;
    logic        wr_strobe;
    logic        busy;

    modport slave  (input scl_in, sda_in, status_in, output sda_oe, reg_out, wr_strobe, busy);
    modport master (output scl_in, sda_in, status_in, input sda_oe, reg_out, wr_strobe, busy);
endinterface

// File: rtl/i2c_target.sv
// I2C target with three writable registers and one read-only status register.
// Define I2C_TARGET_AUTOINC_EN to auto-increment the register pointer per data byte.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic         clk,
    input  logic         reset,
    i2c_target_if.slave  bus
);

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_scl_s1, r_scl_s2, r_scl_h;
    logic        r_sda_s1, r_sda_s2, r_sda_h;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_phase, w_phase_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_strobe, w_wr_en;
    logic [7:0]  r_reg0, r_reg1, r_reg2;
    logic [7:0]  w_rd_byte;
    logic [7:0]  w_byte;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};

    always_comb begin
        case (r_ptr)
            2'd0:    w_rd_byte = r_reg0;
            2'd1:    w_rd_byte = r_reg1;
            2'd2:    w_rd_byte = r_reg2;
            default: w_rd_byte = bus.status_in;
        endcase
    end

    // ACK states use r_phase: 0 until the 9th SCL rise, 1 afterwards.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_phase_nxt = r_phase;
        w_ptr_nxt   = r_ptr;
        w_rw_nxt    = r_rw;
        w_busy_nxt  = r_busy;
        w_oe_nxt    = r_oe;
        w_wr_en     = 1'b0;
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = 3'd0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                ADDR, PTR, WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_nxt = 1'b0;
                            if (r_state == ADDR) begin
                                if (w_byte[7:1] == TARGET_ADDR) begin
                                    w_state_nxt = ADDR_ACK;
                                    w_busy_nxt  = 1'b1;
                                    w_rw_nxt    = w_byte[0];
                                end else begin
                                    w_state_nxt = WAIT_STOP;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == PTR) begin
                                w_ptr_nxt   = w_byte[1:0];
                                w_state_nxt = PTR_ACK;
                            end else begin
                                w_state_nxt = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_phase_nxt = 1'b1;
                    end else if (w_scl_fall && !r_phase) begin
                        w_oe_nxt = 1'b1;
                        if (r_state == WDATA_ACK) begin
                            w_wr_en = (r_ptr != 2'd3);
                            if (AUTOINC) w_ptr_nxt = r_ptr + 2'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_oe_nxt  = 1'b0;
                        w_cnt_nxt = 3'd0;
                        if (r_state == ADDR_ACK && r_rw) begin
                            w_shift_nxt = w_rd_byte;
                            w_oe_nxt    = ~w_rd_byte[7];
                            w_state_nxt = RDATA;
                        end else if (r_state == ADDR_ACK) begin
                            w_state_nxt = PTR;
                        end else begin
                            w_state_nxt = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_nxt = 1'b0;
                            w_state_nxt = RDATA_ACK;
                            if (AUTOINC) w_ptr_nxt = r_ptr + 2'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_oe_nxt    = ~r_shift[6];
                    end
                end
                RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_s2) w_state_nxt = WAIT_STOP;
                        else          w_phase_nxt = 1'b1;
                    end else if (w_scl_fall && !r_phase) begin
                        w_oe_nxt = 1'b0;
                    end else if (w_scl_fall) begin
                        w_shift_nxt = w_rd_byte;
                        w_oe_nxt    = ~w_rd_byte[7];
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_shift  <= 8'h00;
            r_phase  <= 1'b0;
            r_ptr    <= 2'd0;
            r_rw     <= 1'b0;
            r_busy   <= 1'b0;
            r_oe     <= 1'b0;
            r_strobe <= 1'b0;
            r_reg0   <= 8'h00;
            r_reg1   <= 8'h00;
            r_reg2   <= 8'h00;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= {bus.scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_h} <= {bus.sda_in, r_sda_s1, r_sda_s2};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_phase  <= w_phase_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rw     <= w_rw_nxt;
            r_busy   <= w_busy_nxt;
            r_oe     <= w_oe_nxt;
            r_strobe <= w_wr_en;
            if (w_wr_en) begin
                case (r_ptr)
                    2'd0:    r_reg0 <= r_shift;
                    2'd1:    r_reg1 <= r_shift;
                    default: r_reg2 <= r_shift;
                endcase
            end
        end
    end

    assign bus.sda_oe    = r_oe;
    assign bus.busy      = r_busy;
    assign bus.wr_strobe = r_strobe;
    assign bus.reg_out   = {r_reg2, r_reg1, r_reg0};

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master with open-drain SDA model.
module tb_i2c_target;
    localparam int H = 10;

    typedef struct {
        logic        rd;
        logic [7:0]  ptr;
        logic [7:0]  data;
        logic [7:0]  status;
        logic [23:0] exp_reg;
        logic [7:0]  exp_rd;
        int          exp_strb;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_sda = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   strobe_pulses = 0;
    int   strobe_long = 0;
    int   oe_cycles = 0;
    logic prev_strb = 1'b0;
    logic busy_mid;
    int   cur = -1;

    always #5 clk = ~clk;

    i2c_target_if bus ();
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_target #(.TARGET_ADDR(7'h42)) dut (.clk(clk), .reset(reset), .bus(bus));

    always @(posedge clk) begin
        prev_strb <= bus.wr_strobe;
        if (bus.wr_strobe && !prev_strb) strobe_pulses <= strobe_pulses + 1;
        if (bus.wr_strobe && prev_strb)  strobe_long   <= strobe_long + 1;
        if (bus.sda_oe)                  oe_cycles     <= oe_cycles + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; clks(H);
        bus.scl_in = 1'b1; clks(H);
        m_sda = 1'b0; clks(H);
        bus.scl_in = 1'b0; clks(H);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clks(H);
        bus.scl_in = 1'b1; clks(H);
        m_sda = 1'b1; clks(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; clks(H);
        bus.scl_in = 1'b1; clks(H);
        bus.scl_in = 1'b0; clks(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; clks(H);
        bus.scl_in = 1'b1; clks(H / 2);
        ack = ~bus.sda_in; clks(H / 2);
        bus.scl_in = 1'b0; clks(2);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic [7:0] t;
        t = 8'h00;
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            clks(H);
            bus.scl_in = 1'b1; clks(H / 2);
            t[i] = bus.sda_in; clks(H / 2);
            bus.scl_in = 1'b0; clks(2);
        end
        m_sda = ~mack; clks(H);
        bus.scl_in = 1'b1; clks(H);
        bus.scl_in = 1'b0; clks(2);
        m_sda = 1'b1;
        d = t;
    endtask

    task automatic do_write(input logic [7:0] ptr, input logic [7:0] data, output logic [2:0] acks);
        i2c_start();
        write_byte(8'h84, acks[2]);
        busy_mid = bus.busy;
        write_byte(ptr, acks[1]);
        write_byte(data, acks[0]);
        i2c_stop();
        clks(H);
    endtask

    task automatic do_read(input logic [7:0] ptr, output logic [7:0] d, output logic [2:0] acks);
        i2c_start();
        write_byte(8'h84, acks[2]);
        write_byte(ptr, acks[1]);
        i2c_start();
        write_byte(8'h85, acks[0]);
        busy_mid = bus.busy;
        read_byte(1'b0, d);
        i2c_stop();
        clks(H);
    endtask

    vec_t       vt [11];
    logic [2:0] acks;
    logic [7:0] rd, rd2;
    logic       a;
    int         sb, lb, ob;
    logic [23:0] exp_reg;

    initial begin
        vt[0]  = '{1'b1, 8'h02, 8'h00, 8'h00, 24'h000000, 8'h00, 0};
        vt[1]  = '{1'b1, 8'h03, 8'h00, 8'hC3, 24'h000000, 8'hC3, 0};
        vt[2]  = '{1'b0, 8'h01, 8'h5A, 8'h00, 24'h005A00, 8'h00, 1};
        vt[3]  = '{1'b0, 8'h00, 8'h3C, 8'h00, 24'h005A3C, 8'h00, 1};
        vt[4]  = '{1'b0, 8'h02, 8'hFF, 8'h00, 24'hFF5A3C, 8'h00, 1};
        vt[5]  = '{1'b0, 8'h03, 8'h77, 8'h00, 24'hFF5A3C, 8'h00, 0};
        vt[6]  = '{1'b0, 8'h05, 8'h81, 8'h00, 24'hFF813C, 8'h00, 1};
        vt[7]  = '{1'b1, 8'h01, 8'h00, 8'h00, 24'hFF813C, 8'h81, 0};
        vt[8]  = '{1'b1, 8'h02, 8'h00, 8'h00, 24'hFF813C, 8'hFF, 0};
        vt[9]  = '{1'b1, 8'h03, 8'h00, 8'h5E, 24'hFF813C, 8'h5E, 0};
        vt[10] = '{1'b1, 8'h00, 8'h00, 8'h00, 24'hFF813C, 8'h3C, 0};

        bus.scl_in = 1'b1;
        bus.status_in = 8'h00;
        clks(5);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_strobe", 32'(bus.wr_strobe), 32'd0);
        chk("rst_reg_out", 32'(bus.reg_out), 32'd0);
        reset = 1'b0;
        clks(10);

        for (int k = 0; k < 11; k++) begin
            cur = k;
            bus.status_in = vt[k].status;
            sb = strobe_pulses;
            lb = strobe_long;
            if (vt[k].rd) begin
                do_read(vt[k].ptr, rd, acks);
                chk("rd_data", 32'(rd), 32'(vt[k].exp_rd));
            end else begin
                do_write(vt[k].ptr, vt[k].data, acks);
            end
            chk("acks", 32'(acks), 32'h7);
            chk("busy_mid", 32'(busy_mid), 32'd1);
            chk("reg_out", 32'(bus.reg_out), 32'(vt[k].exp_reg));
            chk("strobes", 32'(strobe_pulses - sb), 32'(vt[k].exp_strb));
            chk("strobe_width", 32'(strobe_long - lb), 32'd0);
            chk("busy_end", 32'(bus.busy), 32'd0);
        end

        // Address mismatch: no ACK anywhere, bytes ignored until STOP.
        cur = 100;
        sb = strobe_pulses; ob = oe_cycles;
        i2c_start();
        write_byte(8'h90, a);
        chk("mm_addr_ack", 32'(a), 32'd0);
        chk("mm_busy", 32'(bus.busy), 32'd0);
        write_byte(8'h01, a);
        chk("mm_b1_ack", 32'(a), 32'd0);
        write_byte(8'h5A, a);
        chk("mm_b2_ack", 32'(a), 32'd0);
        i2c_stop();
        clks(H);
        chk("mm_oe_cycles", 32'(oe_cycles - ob), 32'd0);
        chk("mm_reg_out", 32'(bus.reg_out), 32'hFF813C);
        chk("mm_strobes", 32'(strobe_pulses - sb), 32'd0);

        // Multi-byte write starting at register 0.
        cur = 101;
        sb = strobe_pulses; lb = strobe_long;
        i2c_start();
        write_byte(8'h84, acks[2]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h11, acks[0]);
        chk("mb_acks", 32'(acks), 32'h7);
        write_byte(8'h22, a); chk("mb_ack2", 32'(a), 32'd1);
        write_byte(8'h33, a); chk("mb_ack3", 32'(a), 32'd1);
        write_byte(8'h44, a); chk("mb_ack4", 32'(a), 32'd1);
        i2c_stop();
        clks(H);
`ifdef I2C_TARGET_AUTOINC_EN
        exp_reg = 24'h332211;
        chk("mb_strobes", 32'(strobe_pulses - sb), 32'd3);
`else
        exp_reg = 24'hFF8144;
        chk("mb_strobes", 32'(strobe_pulses - sb), 32'd4);
`endif
        chk("mb_reg_out", 32'(bus.reg_out), 32'(exp_reg));
        chk("mb_strobe_width", 32'(strobe_long - lb), 32'd0);

        // Two-byte read with master ACK between bytes.
        cur = 102;
        i2c_start();
        write_byte(8'h84, acks[2]);
        write_byte(8'h00, acks[1]);
        i2c_start();
        write_byte(8'h85, acks[0]);
        read_byte(1'b1, rd);
        read_byte(1'b0, rd2);
        i2c_stop();
        clks(H);
        chk("rr_acks", 32'(acks), 32'h7);
        chk("rr_byte0", 32'(rd), 32'(exp_reg[7:0]));
`ifdef I2C_TARGET_AUTOINC_EN
        chk("rr_byte1", 32'(rd2), 32'(exp_reg[15:8]));
`else
        chk("rr_byte1", 32'(rd2), 32'(exp_reg[7:0]));
`endif

        // STOP in the middle of a data byte leaves registers untouched.
        cur = 103;
        sb = strobe_pulses;
        i2c_start();
        write_byte(8'h84, a);
        chk("ms_addr_ack", 32'(a), 32'd1);
        write_byte(8'h01, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        clks(H);
        chk("ms_reg_out", 32'(bus.reg_out), 32'(exp_reg));
        chk("ms_strobes", 32'(strobe_pulses - sb), 32'd0);
        chk("ms_busy", 32'(bus.busy), 32'd0);

        // Reset during the 4th bit of a read while the target pulls SDA low.
        cur = 104;
        bus.status_in = 8'h00;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h03, a);
        i2c_start();
        write_byte(8'h85, a);
        m_sda = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clks(H);
            bus.scl_in = 1'b1; clks(H);
            bus.scl_in = 1'b0; clks(2);
        end
        clks(H);
        chk("rs_pre_oe", 32'(bus.sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        chk("rs_async_oe", 32'(bus.sda_oe), 32'd0);
        bus.scl_in = 1'b1;
        m_sda = 1'b1;
        clks(5);
        reset = 1'b0;
        clks(10);
        chk("rs_reg_out", 32'(bus.reg_out), 32'd0);
        chk("rs_busy", 32'(bus.busy), 32'd0);
        sb = strobe_pulses;
        do_write(8'h02, 8'h96, acks);
        chk("rs_wr_acks", 32'(acks), 32'h7);
        chk("rs_wr_reg", 32'(bus.reg_out), 32'h960000);
        chk("rs_wr_strobes", 32'(strobe_pulses - sb), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
